constant_addition: RTL and testbench



---
 rtl/ascon_pack.sv | 7 +
 rtl/constant_addition_if.sv | 29 ++
 rtl/constant_addition.sv | 56 +++++
 tb/tb_constant_addition.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared ASCON types: the 320-bit permutation state as five 64-bit words.
package ascon_pack;

  // Word 0 is the most significant word; bit 63 is the MSB of each word.
  typedef logic [0:4][63:0] type_state;

endpackage

// File: rtl/constant_addition_if.sv
// Data path bundle for the constant-addition layer: enable, round index,
// state in/out and result-valid strobe.
interface constant_addition_if;

  logic                 en_i;
  logic [3:0]           round_i;
  ascon_pack::type_state state_i;
  ascon_pack::type_state state_o;
  logic                 valid_o;

  // Upstream controller / permutation driver side.
  modport master (
    output en_i,
    output round_i,
    output state_i,
    input  state_o,
    input  valid_o
  );

  // Constant-addition layer side.
  modport slave (
    input  en_i,
    input  round_i,
    input  state_i,
    output state_o,
    output valid_o
  );

endinterface

// File: rtl/constant_addition.sv
// ASCON-128 constant-addition layer p_C: XORs the round constant into the low
// byte of state word 2 and registers the result (one cycle latency).
module constant_addition
  import ascon_pack::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  constant_addition_if.slave bus
);

  logic [7:0] rc_d;
  type_state  state_d;
  type_state  state_q;
  logic       valid_q;

  // Rounds 12..15 carry no constant, so the state passes through unchanged.
  always_comb begin
    rc_d = '0;
    unique case (bus.round_i)
      4'd0:    rc_d = 8'hF0;
      4'd1:    rc_d = 8'hE1;
      4'd2:    rc_d = 8'hD2;
      4'd3:    rc_d = 8'hC3;
      4'd4:    rc_d = 8'hB4;
      4'd5:    rc_d = 8'hA5;
      4'd6:    rc_d = 8'h96;
      4'd7:    rc_d = 8'h87;
      4'd8:    rc_d = 8'h78;
      4'd9:    rc_d = 8'h69;
      4'd10:   rc_d = 8'h5A;
      4'd11:   rc_d = 8'h4B;
      default: rc_d = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = bus.state_i;
    state_d[2] = bus.state_i[2] ^ {56'h0, rc_d};
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.en_i;
      if (bus.en_i) begin
        state_q <= state_d;
      end
    end
  end

  assign bus.state_o = state_q;
  assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_constant_addition.sv
// Directed bench for constant_addition: reset, reference vectors, full
// constant sweep, hold behaviour and mid-stream reset.
module tb_constant_addition;
  import ascon_pack::*;

  logic clock_i;
  logic reset_i;
  int   checks;
  int   errors;

  constant_addition_if bus ();

  constant_addition dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic test_reset();
    type_state rnd;
    for (int unsigned w = 0; w < 5; w++) rnd[w] = {$urandom, $urandom};
    bus.en_i    = 1'b1;
    bus.round_i = 4'd0;
    bus.state_i = rnd;
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (bus.state_o !== '0 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_immediate: state_o=%h valid_o=%b, required 0/0", bus.state_o, bus.valid_o);
    end
    step();
    checks++;
    if (bus.state_o !== '0 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_with_en: state_o=%h valid_o=%b, required 0/0", bus.state_o, bus.valid_o);
    end
    bus.en_i = 1'b0;
    reset_i  = 1'b0;
    step();
    step();
    checks++;
    if (bus.state_o !== '0 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: state_o=%h valid_o=%b, required 0/0", bus.state_o, bus.valid_o);
    end
  endtask

  task automatic test_vectors();
    type_state in1, exp1, in2, exp2;
    in1 = {64'h80400c0600000000, 64'h8a55114d1cb6a9a2, 64'hbe263d4d7aecaaff,
           64'h4ed0ec0b98c529b7, 64'hc8cddf37bcd0284a};
    exp1 = {64'h80400c0600000000, 64'h8a55114d1cb6a9a2, 64'hbe263d4d7aecaa0f,
            64'h4ed0ec0b98c529b7, 64'hc8cddf37bcd0284a};
    in2 = {64'ha71b22fa2d0f5150, 64'hb11e0a9a608e0016, 64'h076f27ad4d99d5e7,
           64'ha72ac1ad8440b0b7, 64'h0657b0d6eaf9c1c4};
    exp2 = {64'ha71b22fa2d0f5150, 64'hb11e0a9a608e0016, 64'h076f27ad4d99d517,
            64'ha72ac1ad8440b0b7, 64'h0657b0d6eaf9c1c4};

    bus.en_i    = 1'b1;
    bus.round_i = 4'd0;
    bus.state_i = in1;
    step();
    checks++;
    if (bus.state_o !== exp1 || bus.valid_o !== 1'b1) begin
      errors++;
      $display("FAIL vector1: state_o=%h valid_o=%b, required %h/1", bus.state_o, bus.valid_o, exp1);
    end
    bus.state_i = in2;
    step();
    checks++;
    if (bus.state_o !== exp2 || bus.valid_o !== 1'b1) begin
      errors++;
      $display("FAIL vector2: state_o=%h valid_o=%b, required %h/1", bus.state_o, bus.valid_o, exp2);
    end
    bus.en_i = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    logic [7:0] rc_tab [16];
    type_state  exp;
    rc_tab = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87,
               8'h78, 8'h69, 8'h5A, 8'h4B, 8'h00, 8'h00, 8'h00, 8'h00};
    bus.state_i = '0;
    bus.en_i    = 1'b1;
    for (int r = 0; r < 16; r++) begin
      bus.round_i = 4'(r);
      step();
      exp    = '0;
      exp[2] = {56'h0, rc_tab[r]};
      checks++;
      if (bus.state_o !== exp || bus.valid_o !== 1'b1) begin
        errors++;
        $display("FAIL sweep_round%0d: state_o=%h valid_o=%b, required %h/1", r, bus.state_o, bus.valid_o, exp);
      end
    end
    bus.en_i = 1'b0;
    step();
  endtask

  task automatic test_hold();
    type_state in, exp;
    in = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h5555aaaa5555aaaa,
          64'hdeadbeefcafef00d, 64'h0f0f0f0f0f0f0f0f};
    exp    = in;
    exp[2] = 64'h5555aaaa5555aa69;  // round 3: aa ^ c3
    bus.en_i    = 1'b1;
    bus.round_i = 4'd3;
    bus.state_i = in;
    step();
    checks++;
    if (bus.state_o !== exp || bus.valid_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_load: state_o=%h valid_o=%b, required %h/1", bus.state_o, bus.valid_o, exp);
    end
    bus.en_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.state_i = ~in;
      bus.round_i = 4'(c + 7);
      step();
      checks++;
      if (bus.state_o !== exp || bus.valid_o !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: state_o=%h valid_o=%b, required %h/0", c, bus.state_o, bus.valid_o, exp);
      end
    end
  endtask

  task automatic test_midstream_reset();
    type_state exp;
    bus.state_i = '0;
    bus.en_i    = 1'b1;
    for (int r = 0; r < 3; r++) begin
      bus.round_i = 4'(r);
      step();
    end
    // Pulse reset between edges while a result is being presented.
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (bus.state_o !== '0 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_immediate: state_o=%h valid_o=%b, required 0/0", bus.state_o, bus.valid_o);
    end
    reset_i     = 1'b0;
    bus.round_i = 4'd5;
    step();
    exp    = '0;
    exp[2] = 64'h00000000000000A5;
    checks++;
    if (bus.state_o !== exp || bus.valid_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_resume: state_o=%h valid_o=%b, required %h/1", bus.state_o, bus.valid_o, exp);
    end
    bus.en_i = 1'b0;
    step();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset_i     = 1'b0;
    bus.en_i    = 1'b0;
    bus.round_i = '0;
    bus.state_i = '0;
    #1;
    test_reset();
    test_vectors();
    test_sweep();
    test_hold();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
